qam_symbol_loader: RTL and testbench

//  16-QAM symbol source for the angle counter. Serial data bits are packed into
//  4-bit symbols and buffered in a small FIFO. Each carrier-period boundary
//  (counted on Quad_Change) releases one symbol as Gray-mapped signed I/Q

---
 rtl/qam_symbol_loader_pkg.sv | 18 +
 rtl/qam_sym_fifo.sv | 57 +++++
 rtl/qam_symbol_loader.sv | 143 ++++++++++++++
 tb/tb_qam_symbol_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_symbol_loader_pkg.sv
// Shared definitions for the 16-QAM symbol loader: FSM states, level codes
// and symbol width used by the loader, its FIFO and the carrier multiplier.
package qam_symbol_loader_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int SYM_W = 4;

  localparam logic signed [2:0] LVL_M3 = 3'sb101;
  localparam logic signed [2:0] LVL_M1 = 3'sb111;
  localparam logic signed [2:0] LVL_P1 = 3'sb001;
  localparam logic signed [2:0] LVL_P3 = 3'sb011;
  localparam logic signed [2:0] LVL_Z  = 3'sb000;

endpackage

// File: rtl/qam_sym_fifo.sv
// Synchronous symbol FIFO; read data is registered on pop so the head symbol
// appears the cycle after the pop request.
module qam_sym_fifo
  import qam_symbol_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [SYM_W-1:0] push_data,
  input  logic             pop,
  output logic [SYM_W-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [SYM_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage and read register carry no reset; occupancy gates their use.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
    if (do_pop)  rd_data     <= mem[rd_ptr];
  end

endmodule

// File: rtl/qam_symbol_loader.sv
// 16-QAM symbol source: packs serial bits into symbols, queues them, and
// releases one Gray-mapped I/Q pair per carrier-period boundary.
module qam_symbol_loader
  import qam_symbol_loader_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYM_QUADS   = 4,
  parameter int PRIME_LEVEL = 2
) (
  input  logic       CLK_16,
  input  logic       RST,
  input  logic       Quad_Change,
  input  logic       DIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  output logic [2:0] I_LEVEL,
  output logic [2:0] Q_LEVEL,
  output logic       SYM_STROBE,
  output logic       UNDERRUN,
  output logic [2:0] FIFO_LEVEL
);

  localparam int QC_W = (SYM_QUADS > 1) ? $clog2(SYM_QUADS) : 1;

  function automatic logic signed [2:0] map_level(input logic [1:0] pair);
    case (pair)
      2'b00:   return LVL_M3;
      2'b01:   return LVL_M1;
      2'b11:   return LVL_P1;
      default: return LVL_P3;
    endcase
  endfunction

  logic             qc_d;
  logic             qc_rise;
  logic             boundary;
  logic [QC_W-1:0]  quad_cnt;
  logic [2:0]       shift_p0;
  logic [1:0]       bitcnt;
  logic             accept;
  logic             push;
  logic [SYM_W-1:0] push_data;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [2:0]       level;
  logic [SYM_W-1:0] sym_p1;
  state_t           state;
  state_t           state_nxt;
  logic             strobe_nxt;
  logic             out_en_nxt;
  logic             underrun_set;
  logic             vld_p1;
  logic             out_en_p1;
  logic             underrun;

  assign qc_rise   = Quad_Change & ~qc_d;
  assign boundary  = qc_rise & (quad_cnt == QC_W'(SYM_QUADS - 1));
  assign DIN_READY = ~fifo_full | (bitcnt != 2'd3);
  assign accept    = DIN_VALID & DIN_READY;
  assign push      = accept & (bitcnt == 2'd3);
  assign push_data = {shift_p0, DIN};

  qam_sym_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LVL_W      (3)
  ) u_fifo (
    .clk       (CLK_16),
    .rst       (RST),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .rd_data   (sym_p1),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Pop decisions use pre-push occupancy: a symbol landing on the boundary
  // cycle cannot rescue that boundary.
  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    strobe_nxt   = 1'b0;
    out_en_nxt   = out_en_p1;
    underrun_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (boundary && (level >= 3'(PRIME_LEVEL))) begin
          pop        = 1'b1;
          strobe_nxt = 1'b1;
          out_en_nxt = 1'b1;
          state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        if (boundary) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            strobe_nxt = 1'b1;
          end else begin
            underrun_set = 1'b1;
            out_en_nxt   = 1'b0;
            state_nxt    = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // p0 -> p1: boundary decision registered alongside the popped symbol
  always_ff @(posedge CLK_16) begin
    if (RST) begin
      qc_d      <= 1'b0;
      quad_cnt  <= '0;
      bitcnt    <= 2'd0;
      state     <= S_IDLE;
      vld_p1    <= 1'b0;
      out_en_p1 <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      qc_d <= Quad_Change;
      if (qc_rise) quad_cnt <= boundary ? '0 : quad_cnt + 1'b1;
      if (accept)  bitcnt   <= bitcnt + 2'd1;
      state     <= state_nxt;
      vld_p1    <= strobe_nxt;
      out_en_p1 <= out_en_nxt;
      if (underrun_set) underrun <= 1'b1;
    end
  end

  always_ff @(posedge CLK_16) begin
    if (accept) shift_p0 <= {shift_p0[1:0], DIN};
  end

  assign I_LEVEL    = out_en_p1 ? map_level(sym_p1[3:2]) : LVL_Z;
  assign Q_LEVEL    = out_en_p1 ? map_level(sym_p1[1:0]) : LVL_Z;
  assign SYM_STROBE = vld_p1;
  assign UNDERRUN   = underrun;
  assign FIFO_LEVEL = level;

endmodule

// File: tb/tb_qam_symbol_loader.sv
// Directed bench for qam_symbol_loader: priming, run, underrun, full FIFO,
// simultaneous push/pop, Quad_Change edge counting and mid-symbol reset.
module tb_qam_symbol_loader;

  logic       CLK_16 = 1'b0;
  logic       RST = 1'b1;
  logic       Quad_Change = 1'b0;
  logic       DIN = 1'b0;
  logic       DIN_VALID = 1'b0;
  logic       DIN_READY;
  logic [2:0] I_LEVEL;
  logic [2:0] Q_LEVEL;
  logic       SYM_STROBE;
  logic       UNDERRUN;
  logic [2:0] FIFO_LEVEL;

  int n_cmp = 0;
  int n_bad = 0;

  qam_symbol_loader dut (
    .CLK_16      (CLK_16),
    .RST         (RST),
    .Quad_Change (Quad_Change),
    .DIN         (DIN),
    .DIN_VALID   (DIN_VALID),
    .DIN_READY   (DIN_READY),
    .I_LEVEL     (I_LEVEL),
    .Q_LEVEL     (Q_LEVEL),
    .SYM_STROBE  (SYM_STROBE),
    .UNDERRUN    (UNDERRUN),
    .FIFO_LEVEL  (FIFO_LEVEL)
  );

  always #5 CLK_16 = ~CLK_16;

  task automatic step();
    @(posedge CLK_16);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int guard;
    guard = 0;
    DIN = b;
    DIN_VALID = 1'b1;
    while (!DIN_READY && guard < 50) begin
      step();
      guard++;
    end
    n_cmp++;
    if (guard >= 50) begin
      n_bad++;
      $display("FAIL send_bit_timeout: DIN_READY got %b required 1 within 50 cycles", DIN_READY);
    end
    step();
    DIN_VALID = 1'b0;
  endtask

  task automatic send_sym(input logic [3:0] s);
    for (int i = 3; i >= 0; i--) send_bit(s[i]);
  endtask

  task automatic pulse_qc(output logic seen);
    Quad_Change = 1'b1;
    step();
    seen = SYM_STROBE;
    Quad_Change = 1'b0;
    step();
  endtask

  task automatic quad4(output int strobes);
    logic s;
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      pulse_qc(s);
      if (s) strobes++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    n_cmp++; if (I_LEVEL !== 3'b000) begin n_bad++; $display("FAIL rst_i: got %b required 000", I_LEVEL); end
    n_cmp++; if (Q_LEVEL !== 3'b000) begin n_bad++; $display("FAIL rst_q: got %b required 000", Q_LEVEL); end
    n_cmp++; if (SYM_STROBE !== 1'b0) begin n_bad++; $display("FAIL rst_strobe: got %b required 0", SYM_STROBE); end
    n_cmp++; if (UNDERRUN !== 1'b0) begin n_bad++; $display("FAIL rst_underrun: got %b required 0", UNDERRUN); end
    n_cmp++; if (FIFO_LEVEL !== 3'd0) begin n_bad++; $display("FAIL rst_level: got %0d required 0", FIFO_LEVEL); end
    n_cmp++; if (DIN_READY !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b required 1", DIN_READY); end
  endtask

  task automatic test_basic();
    int st;
    do_reset();
    send_sym(4'b1011);
    send_sym(4'b0100);
    n_cmp++; if (FIFO_LEVEL !== 3'd2) begin n_bad++; $display("FAIL basic_level2: got %0d required 2", FIFO_LEVEL); end
    quad4(st);
    n_cmp++; if (st !== 1) begin n_bad++; $display("FAIL basic_strobe1: got %0d required 1", st); end
    n_cmp++; if (I_LEVEL !== 3'b011) begin n_bad++; $display("FAIL basic_i1: got %b required 011", I_LEVEL); end
    n_cmp++; if (Q_LEVEL !== 3'b001) begin n_bad++; $display("FAIL basic_q1: got %b required 001", Q_LEVEL); end
    n_cmp++; if (FIFO_LEVEL !== 3'd1) begin n_bad++; $display("FAIL basic_level1: got %0d required 1", FIFO_LEVEL); end
    quad4(st);
    n_cmp++; if (st !== 1) begin n_bad++; $display("FAIL basic_strobe2: got %0d required 1", st); end
    n_cmp++; if (I_LEVEL !== 3'b111) begin n_bad++; $display("FAIL basic_i2: got %b required 111", I_LEVEL); end
    n_cmp++; if (Q_LEVEL !== 3'b101) begin n_bad++; $display("FAIL basic_q2: got %b required 101", Q_LEVEL); end
    n_cmp++; if (SYM_STROBE !== 1'b0) begin n_bad++; $display("FAIL basic_strobe_width: got %b required 0", SYM_STROBE); end
  endtask

  task automatic test_prime();
    int st;
    do_reset();
    send_sym(4'b1011);
    quad4(st);
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL prime_nostrobe: got %0d required 0", st); end
    n_cmp++; if (I_LEVEL !== 3'b000 || Q_LEVEL !== 3'b000) begin n_bad++; $display("FAIL prime_iq_zero: got I=%b Q=%b required 000/000", I_LEVEL, Q_LEVEL); end
    n_cmp++; if (FIFO_LEVEL !== 3'd1) begin n_bad++; $display("FAIL prime_level: got %0d required 1", FIFO_LEVEL); end
    send_sym(4'b0100);
    quad4(st);
    n_cmp++; if (st !== 1) begin n_bad++; $display("FAIL prime_leave_idle: got %0d required 1", st); end
    n_cmp++; if (I_LEVEL !== 3'b011 || Q_LEVEL !== 3'b001) begin n_bad++; $display("FAIL prime_first_sym: got I=%b Q=%b required 011/001", I_LEVEL, Q_LEVEL); end
  endtask

  task automatic test_underrun();
    int st;
    quad4(st);
    n_cmp++; if (I_LEVEL !== 3'b111 || Q_LEVEL !== 3'b101) begin n_bad++; $display("FAIL ur_second_sym: got I=%b Q=%b required 111/101", I_LEVEL, Q_LEVEL); end
    quad4(st);
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL ur_nostrobe: got %0d required 0", st); end
    n_cmp++; if (UNDERRUN !== 1'b1) begin n_bad++; $display("FAIL ur_flag: got %b required 1", UNDERRUN); end
    n_cmp++; if (I_LEVEL !== 3'b000 || Q_LEVEL !== 3'b000) begin n_bad++; $display("FAIL ur_iq_zero: got I=%b Q=%b required 000/000", I_LEVEL, Q_LEVEL); end
    send_sym(4'b1011);
    quad4(st);
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL ur_back_idle: got %0d strobes required 0", st); end
    send_sym(4'b0100);
    quad4(st);
    n_cmp++; if (st !== 1) begin n_bad++; $display("FAIL ur_restart: got %0d required 1", st); end
    n_cmp++; if (UNDERRUN !== 1'b1) begin n_bad++; $display("FAIL ur_sticky: got %b required 1", UNDERRUN); end
    do_reset();
    n_cmp++; if (UNDERRUN !== 1'b0) begin n_bad++; $display("FAIL ur_rst_clear: got %b required 0", UNDERRUN); end
  endtask

  task automatic test_full();
    int acc;
    int st;
    logic r;
    logic s;
    do_reset();
    acc = 0;
    st = 0;
    DIN = 1'b1;
    DIN_VALID = 1'b1;
    for (int i = 0; i < 25; i++) begin
      r = DIN_READY;
      step();
      if (r) acc++;
    end
    n_cmp++; if (acc !== 19) begin n_bad++; $display("FAIL full_accepted: got %0d required 19", acc); end
    n_cmp++; if (FIFO_LEVEL !== 3'd4) begin n_bad++; $display("FAIL full_level: got %0d required 4", FIFO_LEVEL); end
    n_cmp++; if (DIN_READY !== 1'b0) begin n_bad++; $display("FAIL full_ready_low: got %b required 0", DIN_READY); end
    for (int p = 0; p < 4; p++) begin
      Quad_Change = 1'b1;
      r = DIN_READY;
      step();
      if (r) acc++;
      s = SYM_STROBE;
      if (s) st++;
      Quad_Change = 1'b0;
      r = DIN_READY;
      step();
      if (r) acc++;
    end
    DIN_VALID = 1'b0;
    n_cmp++; if (acc !== 20) begin n_bad++; $display("FAIL full_after_pop: got %0d accepted required 20", acc); end
    n_cmp++; if (st !== 1) begin n_bad++; $display("FAIL full_strobe: got %0d required 1", st); end
    n_cmp++; if (FIFO_LEVEL !== 3'd4) begin n_bad++; $display("FAIL full_refill: got %0d required 4", FIFO_LEVEL); end
    n_cmp++; if (I_LEVEL !== 3'b001 || Q_LEVEL !== 3'b001) begin n_bad++; $display("FAIL full_sym: got I=%b Q=%b required 001/001", I_LEVEL, Q_LEVEL); end
  endtask

  task automatic test_back_to_back();
    int st;
    logic s;
    do_reset();
    send_sym(4'b1011);
    send_sym(4'b0100);
    quad4(st);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    for (int i = 0; i < 3; i++) pulse_qc(s);
    DIN = 1'b1;
    DIN_VALID = 1'b1;
    Quad_Change = 1'b1;
    step();
    DIN_VALID = 1'b0;
    Quad_Change = 1'b0;
    n_cmp++; if (FIFO_LEVEL !== 3'd1) begin n_bad++; $display("FAIL b2b_level: got %0d required 1", FIFO_LEVEL); end
    n_cmp++; if (SYM_STROBE !== 1'b1) begin n_bad++; $display("FAIL b2b_strobe: got %b required 1", SYM_STROBE); end
    n_cmp++; if (I_LEVEL !== 3'b111 || Q_LEVEL !== 3'b101) begin n_bad++; $display("FAIL b2b_sym: got I=%b Q=%b required 111/101", I_LEVEL, Q_LEVEL); end
    step();
    quad4(st);
    n_cmp++; if (I_LEVEL !== 3'b101 || Q_LEVEL !== 3'b111 || FIFO_LEVEL !== 3'd0) begin n_bad++; $display("FAIL b2b_pushed_sym: got I=%b Q=%b L=%0d required 101/111/0", I_LEVEL, Q_LEVEL, FIFO_LEVEL); end
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    for (int i = 0; i < 3; i++) pulse_qc(s);
    DIN = 1'b0;
    DIN_VALID = 1'b1;
    Quad_Change = 1'b1;
    step();
    DIN_VALID = 1'b0;
    Quad_Change = 1'b0;
    n_cmp++; if (UNDERRUN !== 1'b1) begin n_bad++; $display("FAIL b2b_underrun: got %b required 1", UNDERRUN); end
    n_cmp++; if (FIFO_LEVEL !== 3'd1) begin n_bad++; $display("FAIL b2b_retained: got %0d required 1", FIFO_LEVEL); end
    n_cmp++; if (SYM_STROBE !== 1'b0 || I_LEVEL !== 3'b000 || Q_LEVEL !== 3'b000) begin n_bad++; $display("FAIL b2b_ur_out: got S=%b I=%b Q=%b required 0/000/000", SYM_STROBE, I_LEVEL, Q_LEVEL); end
    step();
    send_sym(4'b1000);
    quad4(st);
    n_cmp++; if (st !== 1 || I_LEVEL !== 3'b001 || Q_LEVEL !== 3'b011) begin n_bad++; $display("FAIL b2b_kept_sym: got st=%0d I=%b Q=%b required 1/001/011", st, I_LEVEL, Q_LEVEL); end
  endtask

  task automatic test_qc_and_reset();
    int st;
    logic s;
    do_reset();
    send_sym(4'b1011);
    send_sym(4'b0100);
    st = 0;
    Quad_Change = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (SYM_STROBE) st++;
    end
    Quad_Change = 1'b0;
    step();
    pulse_qc(s); if (s) st++;
    pulse_qc(s); if (s) st++;
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL qc_hold_once: got %0d strobes required 0", st); end
    pulse_qc(s);
    n_cmp++; if (s !== 1'b1 || I_LEVEL !== 3'b011) begin n_bad++; $display("FAIL qc_fourth_rise: got S=%b I=%b required 1/011", s, I_LEVEL); end
    pulse_qc(s);
    pulse_qc(s);
    send_bit(1'b1); send_bit(1'b1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    n_cmp++; if (I_LEVEL !== 3'b000 || Q_LEVEL !== 3'b000 || SYM_STROBE !== 1'b0) begin n_bad++; $display("FAIL mrst_out: got I=%b Q=%b S=%b required 000/000/0", I_LEVEL, Q_LEVEL, SYM_STROBE); end
    n_cmp++; if (FIFO_LEVEL !== 3'd0 || DIN_READY !== 1'b1 || UNDERRUN !== 1'b0) begin n_bad++; $display("FAIL mrst_state: got L=%0d R=%b U=%b required 0/1/0", FIFO_LEVEL, DIN_READY, UNDERRUN); end
    send_bit(1'b0); send_bit(1'b1);
    n_cmp++; if (FIFO_LEVEL !== 3'd0) begin n_bad++; $display("FAIL mrst_partial: got %0d required 0", FIFO_LEVEL); end
    send_bit(1'b0); send_bit(1'b0);
    n_cmp++; if (FIFO_LEVEL !== 3'd1) begin n_bad++; $display("FAIL mrst_newsym: got %0d required 1", FIFO_LEVEL); end
    send_sym(4'b1011);
    st = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_qc(s);
      if (s) st++;
    end
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL mrst_qcnt_clear: got %0d strobes required 0", st); end
    pulse_qc(s);
    n_cmp++; if (s !== 1'b1 || I_LEVEL !== 3'b111 || Q_LEVEL !== 3'b101) begin n_bad++; $display("FAIL mrst_boundary: got S=%b I=%b Q=%b required 1/111/101", s, I_LEVEL, Q_LEVEL); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prime();
    test_underrun();
    test_full();
    test_back_to_back();
    test_qc_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
